// File: rtl/ws2812b_frame_ctrl_pkg.sv
// Shared constants for the WS2812B receive sequencer: register map,
// register bit positions, sequencer states and the default idle threshold.
package ws2812b_pkg;

    localparam int IDLE_DEFAULT = 3200;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_COLOR  = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_THRESH = 4'hC;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STAT_NEW     = 0;
    localparam int STAT_IDLE    = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_SYNC     = 2'd1,
        S_CAPTURE  = 2'd2,
        S_PASS     = 2'd3
    } state_t;

endpackage

// File: rtl/ws2812b_frame_ctrl_if.sv
// CPU register bus of the WS2812B receive sequencer.
interface ws2812b_frame_ctrl_if;

    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic [31:0] reg_rdata;

    modport master (output reg_addr, output reg_wdata, output reg_we, input reg_rdata);
    modport slave  (input reg_addr, input reg_wdata, input reg_we, output reg_rdata);

endinterface

// File: rtl/ws2812b_frame_ctrl_idle_det.sv
// Line-idle detector: counts consecutive low cycles of DIN (saturating)
// and flags idle once the count reaches the programmable threshold.
module ws2812b_idle_det #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_din,
    input  logic [CNT_W-1:0] i_thresh,
    output logic             o_idle
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_idle;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_din) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Threshold is never 0, so a high line always forces idle low next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idle <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idle <= (w_cnt_nxt >= i_thresh);
        end
    end

    assign o_idle = r_idle;

endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// WS2812B receive sequencer: assembles decoded bits into bytes, captures the
// first GRB triplet after each line-idle gap and owns the register file.
module ws2812b_frame_ctrl #(
    parameter int IDLE_DEFAULT = ws2812b_pkg::IDLE_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_sync,
    input  logic       bit_valid,
    input  logic       bit_value,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       idle,
    output logic       irq,
    ws2812b_frame_ctrl_if.slave bus
);
    import ws2812b_pkg::*;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ctrl;
    logic [CNT_W-1:0] r_thresh;
    logic [23:0]      r_color;
    logic [7:0]       r_g, r_r, r_frame_cnt, r_byte_data;
    logic [6:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [1:0]       r_byte_cnt;
    logic             r_byte_valid, r_new_color, r_overrun, r_irq;
    logic             w_idle, w_en, w_flush, w_capture;
    logic             w_wr_ctrl, w_wr_status, w_wr_thresh;
    logic             w_new_color_nxt, w_overrun_nxt;
    logic             w_unused_wdata;

    ws2812b_idle_det #(.CNT_W(CNT_W)) u_idle_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_din    (din_sync),
        .i_thresh (r_thresh),
        .o_idle   (w_idle)
    );

    assign w_en        = r_ctrl[CTRL_EN];
    assign w_flush     = !w_en || w_idle || !(r_state == S_CAPTURE || r_state == S_PASS);
    assign w_capture   = w_en && !w_idle && (r_state == S_CAPTURE) && r_byte_valid
                         && (r_byte_cnt == 2'd3);
    assign w_wr_ctrl   = bus.reg_we && (bus.reg_addr == ADDR_CTRL);
    assign w_wr_status = bus.reg_we && (bus.reg_addr == ADDR_STATUS);
    assign w_wr_thresh = bus.reg_we && (bus.reg_addr == ADDR_THRESH);

    // A capture in the same cycle as a write-1-clear keeps the sticky bit set.
    assign w_new_color_nxt = w_capture ? 1'b1 :
                             (w_wr_status && bus.reg_wdata[STAT_NEW]) ? 1'b0 : r_new_color;
    assign w_overrun_nxt   = (w_capture && r_new_color) ? 1'b1 :
                             (w_wr_status && bus.reg_wdata[STAT_OVERRUN]) ? 1'b0 : r_overrun;
    assign w_unused_wdata  = ^bus.reg_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_DISABLED;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_en) begin
            w_state_nxt = S_DISABLED;
        end else begin
            case (r_state)
                S_DISABLED: w_state_nxt = S_SYNC;
                S_SYNC:     if (w_idle) w_state_nxt = S_CAPTURE;
                S_CAPTURE:  if (w_capture) w_state_nxt = S_PASS;
                S_PASS:     if (w_idle) w_state_nxt = S_CAPTURE;
                default:    w_state_nxt = S_DISABLED;
            endcase
        end
    end

    // Byte assembly; the byte counter saturates at 3 so PASS keeps pulsing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_g          <= '0;
            r_r          <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_flush) begin
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else begin
                if (bit_valid) begin
                    r_shift   <= {r_shift[5:0], bit_value};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_valid <= 1'b1;
                        r_byte_data  <= {r_shift, bit_value};
                        if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                if (r_byte_valid && (r_state == S_CAPTURE)) begin
                    if (r_byte_cnt == 2'd1) r_g <= r_byte_data;
                    if (r_byte_cnt == 2'd2) r_r <= r_byte_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl      <= '0;
            r_thresh    <= CNT_W'(IDLE_DEFAULT);
            r_color     <= '0;
            r_frame_cnt <= '0;
            r_new_color <= 1'b0;
            r_overrun   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= bus.reg_wdata[1:0];
            if (w_wr_thresh) begin
                r_thresh <= (bus.reg_wdata[CNT_W-1:0] == '0) ? CNT_W'(1)
                                                              : bus.reg_wdata[CNT_W-1:0];
            end
            if (w_capture) begin
                r_color     <= {r_r, r_g, r_byte_data};
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            r_new_color <= w_new_color_nxt;
            r_overrun   <= w_overrun_nxt;
            r_irq       <= w_new_color_nxt & r_ctrl[CTRL_IRQ_EN];
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            ADDR_CTRL:   bus.reg_rdata = {30'd0, r_ctrl};
            ADDR_COLOR:  bus.reg_rdata = {8'h00, r_color};
            ADDR_STATUS: bus.reg_rdata = {16'd0, r_frame_cnt, 5'd0, r_overrun, w_idle, r_new_color};
            ADDR_THRESH: bus.reg_rdata = 32'(r_thresh);
            default:     bus.reg_rdata = '0;
        endcase
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign idle       = w_idle;
    assign irq        = r_irq;

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Self-checking bench for ws2812b_frame_ctrl: drives bit/idle traffic and
// register accesses, and compares against a frame-level reference model.
module tb_ws2812b_frame_ctrl;
    import ws2812b_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_sync = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_value = 1'b0;
    logic       byte_valid, idle, irq;
    logic [7:0] byte_data;

    ws2812b_frame_ctrl_if bus();

    ws2812b_frame_ctrl #(.IDLE_DEFAULT(3200), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_sync   (din_sync),
        .bit_valid  (bit_valid),
        .bit_value  (bit_value),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .idle       (idle),
        .irq        (irq),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Monitor: collect every byte_valid pulse and the cycle irq last rose.
    int         cyc = 0;
    int         irq_rise_cyc = -1;
    logic       irq_d = 1'b0;
    logic [7:0] obs_q[$];
    int         pulse_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (byte_valid === 1'b1) begin
            obs_q.push_back(byte_data);
            pulse_cyc.push_back(cyc);
        end
        if (irq === 1'b1 && irq_d === 1'b0) irq_rise_cyc <= cyc;
        irq_d <= irq;
    end

    // Reference model state, updated per frame.
    logic [7:0]  frm[$];
    logic        m_new = 1'b0;
    logic        m_ovr = 1'b0;
    logic [7:0]  m_frame = 8'd0;
    logic [31:0] m_color = 32'd0;

    function automatic logic [31:0] m_status();
        return {16'd0, m_frame, 5'd0, m_ovr, 1'b0, m_new};
    endfunction

    task automatic model_clear(input logic [31:0] mask);
        if (mask[0]) m_new = 1'b0;
        if (mask[2]) m_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [31:0] clr3);
        if (frm.size() >= 3) begin
            m_ovr   = m_new ? 1'b1 : (clr3[2] ? 1'b0 : m_ovr);
            m_new   = 1'b1;
            m_frame = m_frame + 8'd1;
            m_color = {8'h00, frm[1], frm[0], frm[2]};
        end else begin
            model_clear(clr3);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.reg_addr = a; bus.reg_wdata = d; bus.reg_we = 1'b1;
        @(negedge clk);
        bus.reg_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.reg_addr = a;
        #1 d = bus.reg_rdata;
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        din_sync = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One bit cell: short high pulse on DIN, then a decoded-bit strobe.
    // A non-zero clr issues a STATUS write during the resulting byte_valid cycle.
    task automatic send_bit(input logic b, input logic [31:0] clr);
        @(negedge clk) din_sync = 1'b1;
        @(negedge clk);
        @(negedge clk) din_sync = 1'b0;
        @(negedge clk) begin bit_valid = 1'b1; bit_value = b; end
        @(negedge clk) bit_valid = 1'b0;
        if (clr != 32'd0) begin
            bus.reg_addr = ADDR_STATUS; bus.reg_wdata = clr; bus.reg_we = 1'b1;
            @(negedge clk) bus.reg_we = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [31:0] clr);
        for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0) ? clr : 32'd0);
    endtask

    task automatic send_frame(input logic [31:0] clr3);
        for (int k = 0; k < frm.size(); k++) send_byte(frm[k], (k == 2) ? clr3 : 32'd0);
    endtask

    task automatic settle(output logic [31:0] color, output logic [31:0] status);
        repeat (3) @(negedge clk);
        rd(ADDR_COLOR, color);
        rd(ADDR_STATUS, status);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
        n_checks++; if (byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_byte_data got %h want 00", byte_data); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        rst_n = 1'b1;
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle got %b want 0", idle); end
        rd(ADDR_CTRL, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", d); end
        rd(ADDR_COLOR, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_color got %h want 0", d); end
        rd(ADDR_STATUS, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want 0", d); end
        rd(ADDR_THRESH, d);
        n_checks++; if (d !== 32'd3200) begin n_fail++; $display("FAIL reset_thresh got %0d want 3200", d); end
        rd(4'h2, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", d); end
    endtask

    task automatic test_first_frame();
        logic [31:0] color, status;
        wr(ADDR_CTRL, 32'h3);
        gap(3300);
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL default_idle got %b want 1", idle); end
        rd(ADDR_STATUS, status);
        n_checks++; if (status[STAT_IDLE] !== 1'b1) begin n_fail++; $display("FAIL status_idle_bit got %b want 1", status[STAT_IDLE]); end
        obs_q.delete(); pulse_cyc.delete();
        frm = '{8'hFF, 8'h10, 8'h20};
        send_frame(32'd0);
        model_frame(32'd0);
        settle(color, status);
        n_checks++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL first_pulse_count got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== frm[i]) begin
                n_fail++; $display("FAIL first_byte%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, frm[i]);
            end
        end
        n_checks++; if (color !== 32'h0010FF20) begin n_fail++; $display("FAIL first_color got %h want 0010FF20", color); end
        n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL first_status got %h want %h", status, m_status()); end
        n_checks++;
        if (pulse_cyc.size() < 3 || irq_rise_cyc != pulse_cyc[2] + 1) begin
            n_fail++; $display("FAIL irq_latency got rise at %0d want one cycle after pulse 3", irq_rise_cyc);
        end
    endtask

    task automatic test_thresh();
        logic [31:0] d;
        wr(ADDR_THRESH, 32'd0);
        rd(ADDR_THRESH, d);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL thresh_zero got %0d want 1", d); end
        wr(ADDR_THRESH, 32'd1000);
        gap(100);
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL below_thresh_idle got %b want 0", idle); end
        wr(ADDR_THRESH, 32'd50);
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL thresh_write_idle_early got %b want 0", idle); end
        @(negedge clk);
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL thresh_lowered_idle got %b want 1", idle); end
        wr(ADDR_THRESH, 32'd40);
        rd(ADDR_THRESH, d);
        n_checks++; if (d !== 32'd40) begin n_fail++; $display("FAIL thresh_rw got %0d want 40", d); end
    endtask

    task automatic test_clear_and_pass();
        logic [31:0] color, status;
        wr(ADDR_STATUS, 32'h1);
        model_clear(32'h1);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
        gap(50);
        obs_q.delete();
        frm = '{8'h01, 8'h02, 8'h03, 8'hAA};
        send_frame(32'd0);
        model_frame(32'd0);
        settle(color, status);
        n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL pass_pulse_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== frm[i]) begin
                n_fail++; $display("FAIL pass_byte%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, frm[i]);
            end
        end
        n_checks++; if (color !== 32'h00020103) begin n_fail++; $display("FAIL pass_color got %h want 00020103", color); end
        n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL pass_status got %h want %h", status, m_status()); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pass_irq got %b want 1", irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] color, status;
        gap(50);
        frm = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(32'd0);
        model_frame(32'd0);
        settle(color, status);
        n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL overrun_set got %h want %h", status, m_status()); end
        n_checks++; if (color !== m_color) begin n_fail++; $display("FAIL overrun_color got %h want %h", color, m_color); end
        wr(ADDR_STATUS, 32'h1);
        model_clear(32'h1);
        gap(50);
        frm = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(32'h5);
        model_frame(32'h5);
        settle(color, status);
        n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL clear_vs_capture got %h want %h", status, m_status()); end
        n_checks++; if (color !== m_color) begin n_fail++; $display("FAIL clear_vs_capture_color got %h want %h", color, m_color); end
    endtask

    task automatic test_partial_byte();
        logic [31:0] color, status;
        wr(ADDR_STATUS, 32'h5);
        model_clear(32'h5);
        obs_q.delete();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 32'd0);
        gap(50);
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL partial_gap_idle got %b want 1", idle); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL partial_no_pulse got %0d want 0", obs_q.size()); end
        frm = '{8'h11, 8'h22, 8'h33};
        send_frame(32'd0);
        model_frame(32'd0);
        settle(color, status);
        n_checks++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL partial_pulse_count got %0d want 3", obs_q.size()); end
        n_checks++; if (color !== 32'h00221133) begin n_fail++; $display("FAIL partial_color got %h want 00221133", color); end
        n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL partial_status got %h want %h", status, m_status()); end
    endtask

    task automatic test_random_frames();
        logic [31:0] color, status;
        int n;
        for (int k = 0; k < 5; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr(ADDR_STATUS, 32'h5);
                model_clear(32'h5);
            end
            gap(45 + $urandom_range(0, 20));
            n = $urandom_range(1, 5);
            frm.delete();
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
            obs_q.delete();
            send_frame(32'd0);
            model_frame(32'd0);
            settle(color, status);
            n_checks++; if (obs_q.size() != n) begin n_fail++; $display("FAIL rand%0d_pulse_count got %0d want %0d", k, obs_q.size(), n); end
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (i >= obs_q.size() || obs_q[i] !== frm[i]) begin
                    n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", k, i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, frm[i]);
                end
            end
            n_checks++; if (color !== m_color) begin n_fail++; $display("FAIL rand%0d_color got %h want %h", k, color, m_color); end
            n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL rand%0d_status got %h want %h", k, status, m_status()); end
            n_checks++; if (irq !== m_new) begin n_fail++; $display("FAIL rand%0d_irq got %b want %b", k, irq, m_new); end
        end
    endtask

    task automatic test_enable_midstream();
        logic [31:0] color, status;
        wr(ADDR_CTRL, 32'h0);
        obs_q.delete();
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 32'd0);
        wr(ADDR_CTRL, 32'h3);
        for (int i = 0; i < 16; i++) send_bit(1'($urandom), 32'd0);
        repeat (3) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL sync_no_pulse got %0d want 0", obs_q.size()); end
        gap(50);
        frm = '{8'($urandom), 8'($urandom)};
        send_frame(32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 32'd0);
        wr(ADDR_CTRL, 32'h0);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 32'd0);
        settle(color, status);
        n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL disable_pulse_count got %0d want 2", obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== frm[i]) begin
                n_fail++; $display("FAIL midstream_byte%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, frm[i]);
            end
        end
        n_checks++; if (color !== m_color) begin n_fail++; $display("FAIL disable_color_kept got %h want %h", color, m_color); end
        n_checks++; if (status !== m_status()) begin n_fail++; $display("FAIL disable_status_kept got %h want %h", status, m_status()); end
    endtask

    initial begin
        bus.reg_addr = 4'h0;
        bus.reg_wdata = 32'd0;
        bus.reg_we = 1'b0;
        test_reset();
        test_first_frame();
        test_thresh();
        test_clear_and_pass();
        test_overrun();
        test_partial_byte();
        test_random_frames();
        test_enable_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
